periph_bus_arbiter: RTL and testbench
=====================================

# periph_bus_arbiter

Two-requester arbiter and sequencer for the TinyQV-style peripheral register bus (6-bit address, 32-bit data, 2-bit active-low write/read width strobes, `data_ready` handshake). It sits between the SPI register bridge (requester 0) and an on-chip autonomous agent such as a sample-drain engine (requester 1), and the PDM microphone peripheral.

- Serialises transactions and applies round-robin fairness.
- Registers all peripheral-side strobes.
- Masks read data to the transaction width.
- Aborts reads the peripheral never acknowledges.

## Interface
Parameters:
- `ADDR_W`, 6, peripheral address width
- `DATA_W`, 32, data width (byte/half masking assumes 32)
- `TIMEOUT`, 255, max cycles waiting for `p_data_ready` on a read

Ports. Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset

Requester ports, N = 0, 1:
- `rN_addr`  in  ADDR_W  request address
- `rN_wdata`  in  32  write data
- `rN_write_n`  in  2  write width; 11 = none
- `rN_read_n`  in  2  read width; 11 = none
- `rN_rdata`  out  32  masked read data, valid while `rN_ready`
- `rN_ready`  out  1  one-cycle completion pulse
- `rN_err`  out  1  with `rN_ready`: read timed out

Peripheral and status ports:
- `p_address`  out  ADDR_W  peripheral address
- `p_data_in`  out  32  peripheral write data
- `p_data_write_n`  out  2  peripheral write strobe
- `p_data_read_n`  out  2  peripheral read strobe
- `p_data_out`  in  32  peripheral read data
- `p_data_ready`  in  1  peripheral read acknowledge
- `busy`  out  1  state != IDLE

## Operation
Request and encoding:
- A request is pending when `rN_write_n != 11` or `rN_read_n != 11`.
- The requester holds request, address and data stable until it sees `rN_ready`, then deasserts the request on the next cycle.
- If both write and read are non-11, the request is a write; the read is ignored.
- Width codes: 00 byte, 01 half, 10 word.

FSM states: IDLE, WR, RD, RESP.
- **IDLE**
  - Eligible = pending and not the requester served in the immediately preceding RESP.
  - One eligible requester: grant it.
  - Both eligible: grant the one not equal to `last_grant`.
  - On grant: latch `sel`, address, wdata and width code; update `last_grant`; go to WR (write) or RD (read).
- **WR**
  - `p_data_write_n` = latched code for exactly one cycle.
  - Go to RESP.
- **RD**
  - `p_data_read_n` = latched code, held every cycle in RD.
  - Timeout counter increments each RD cycle.
  - If `p_data_ready` is high: capture `p_data_out` masked and go to RESP.
    - Byte: [31:8] = 0.
    - Half: [31:16] = 0.
    - Word: unchanged.
  - Else, if the counter reaches TIMEOUT: rdata = 0, set err, go to RESP.
- **RESP**
  - `r[sel]_ready` = 1 for one cycle; `r[sel]_err` = err.
  - `rdata` presented on `r[sel]_rdata`; the other requester's `rdata` stays 0.
  - Clear counter and err.
  - Go to IDLE.

Held values:
- `p_address` and `p_data_in` hold the latched values from grant until the next grant.
- Strobes are 11 in every state other than their own.

Reset, asynchronous, any state:
- State IDLE.
- `p_data_write_n` = `p_data_read_n` = 11.
- `p_address` = 0, `p_data_in` = 0.
- All `rN_ready`/`rN_err`/`rN_rdata` = 0.
- `busy` = 0.
- `last_grant` = 1, so r0 wins the first tie.
- Counter 0, served-mask clear.
- A transaction cut by reset is not completed; requesters re-issue.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Write: request seen in IDLE at cycle 0; strobe at cycle 1; `rN_ready` at cycle 2. Minimum 3 cycles per write; back-to-back same requester every 4 cycles.
- Read: request at cycle 0; strobe from cycle 1; `p_data_ready` sampled at cycle k; `rN_ready` + data at k+1.
- Timeout: `p_data_ready` never arrives → RESP at cycle 1+TIMEOUT, err = 1, rdata = 0.
- `p_data_ready` in the same cycle as timeout expiry: data wins, err = 0.
- `p_data_ready` outside RD: ignored.
- A new request arriving during any non-IDLE state waits; no queueing beyond the held request.

## Structure
- Package `periph_bus_pkg`:
  - `TXN_BYTE`=2'b00, `TXN_HALF`=2'b01, `TXN_WORD`=2'b10, `TXN_NONE`=2'b11
  - FSM state enum
  - Timeout counter width `$clog2(TIMEOUT+1)`
- Sub-module `txn_data_mask`: combinational width mask (32-bit data + 2-bit code → masked data), reused by the SPI bridge wrapper.

## Test plan
- r0 word write addr 0x05 data 0xDEADBEEF → `p_data_write_n`=10 for one cycle at cycle 1 with `p_address`=0x05, `p_data_in`=0xDEADBEEF; `r0_ready` at cycle 2, `r0_err`=0.
- r1 byte read addr 0x10; peripheral returns 0x12345678 with `p_data_ready` 3 cycles into RD → `r1_rdata`=0x00000078, `r1_ready` one cycle later; half read of the same → 0x00005678.
- r0 and r1 request in the same cycle after reset → r0 served first, then r1; both holding continuously → grants strictly alternate r0,r1,r0,r1.
- Read with `p_data_ready` held low, TIMEOUT=255 → RESP 256 cycles after request, `rN_err`=1, `rdata`=0, strobe back to 11; ready coinciding with expiry → err=0, data returned.
- `rst_n` low mid-RD → strobes 11, `busy`=0, no `rN_ready`; after release, a re-issued r1 request is granted from IDLE normally.
- Request with both write_n=10 and read_n=10 → single write strobe, no read strobe.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared encodings for the peripheral register bus arbiter.
// Holds width codes, the FSM state type and the timeout counter sizing.
package periph_bus_pkg;

    localparam logic [1:0] TXN_BYTE = 2'b00;
    localparam logic [1:0] TXN_HALF = 2'b01;
    localparam logic [1:0] TXN_WORD = 2'b10;
    localparam logic [1:0] TXN_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    localparam int DEFAULT_TIMEOUT = 255;

    function automatic int to_cnt_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int TO_CNT_W = to_cnt_w(DEFAULT_TIMEOUT);

endpackage

// File: rtl/txn_data_mask.sv
// Zero-extends read data to the transaction width (byte, half or word).
// Shared with the SPI bridge wrapper so both sides mask identically.
module txn_data_mask
    import periph_bus_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [1:0]  code,
    output logic [31:0] data_out
);

    always_comb begin
        data_out = '0;
        case (code)
            TXN_BYTE: data_out = {24'h0, data_in[7:0]};
            TXN_HALF: data_out = {16'h0, data_in[15:0]};
            TXN_WORD: data_out = data_in;
            default:  data_out = '0;
        endcase
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the peripheral register bus.
// All outputs are registered; reads the peripheral never acknowledges are aborted with err.
module periph_bus_arbiter
    import periph_bus_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    input  logic [1:0]        r0_write_n,
    input  logic [1:0]        r0_read_n,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_ready,
    output logic              r0_err,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    input  logic [1:0]        r1_write_n,
    input  logic [1:0]        r1_read_n,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_ready,
    output logic              r1_err,
    output logic [ADDR_W-1:0] p_address,
    output logic [DATA_W-1:0] p_data_in,
    output logic [1:0]        p_data_write_n,
    output logic [1:0]        p_data_read_n,
    input  logic [DATA_W-1:0] p_data_out,
    input  logic              p_data_ready,
    output logic              busy
);

    localparam int CNT_W = to_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic              last_grant_q, last_grant_d;
    logic [1:0]        served_q, served_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        wr_n_q, wr_n_d;
    logic [1:0]        rd_n_q, rd_n_d;
    logic [1:0]        ready_q, ready_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              busy_q, busy_d;

    logic [1:0]        pend, elig;
    logic              grant_sel;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_wn, req_rn;
    logic [DATA_W-1:0] masked;
    logic [CNT_W-1:0]  cnt_inc;

    txn_data_mask u_mask (
        .data_in  (p_data_out),
        .code     (code_q),
        .data_out (masked)
    );

    // The requester served in the last RESP is still holding its request for one cycle.
    always_comb begin
        pend[0]   = (r0_write_n != TXN_NONE) || (r0_read_n != TXN_NONE);
        pend[1]   = (r1_write_n != TXN_NONE) || (r1_read_n != TXN_NONE);
        elig      = pend & ~served_q;
        grant_sel = (elig == 2'b11) ? ~last_grant_q : elig[1];
        req_addr  = grant_sel ? r1_addr    : r0_addr;
        req_wdata = grant_sel ? r1_wdata   : r0_wdata;
        req_wn    = grant_sel ? r1_write_n : r0_write_n;
        req_rn    = grant_sel ? r1_read_n  : r0_read_n;
        cnt_inc   = cnt_q + CNT_W'(1);
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        served_d     = served_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        code_d       = code_q;
        cnt_d        = cnt_q;
        wr_n_d       = TXN_NONE;
        rd_n_d       = TXN_NONE;
        ready_d      = '0;
        err_d        = '0;
        rdata0_d     = '0;
        rdata1_d     = '0;
        case (state_q)
            ST_IDLE: begin
                served_d = '0;
                cnt_d    = '0;
                if (|elig) begin
                    sel_d        = grant_sel;
                    last_grant_d = grant_sel;
                    addr_d       = req_addr;
                    wdata_d      = req_wdata;
                    if (req_wn != TXN_NONE) begin
                        code_d  = req_wn;
                        wr_n_d  = req_wn;
                        state_d = ST_WR;
                    end else begin
                        code_d  = req_rn;
                        rd_n_d  = req_rn;
                        state_d = ST_RD;
                    end
                end
            end
            ST_WR: begin
                ready_d[sel_q] = 1'b1;
                state_d        = ST_RESP;
            end
            ST_RD: begin
                cnt_d = cnt_inc;
                if (p_data_ready) begin
                    ready_d[sel_q] = 1'b1;
                    if (sel_q) rdata1_d = masked;
                    else       rdata0_d = masked;
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else if (cnt_inc == TO_LIMIT) begin
                    ready_d[sel_q] = 1'b1;
                    err_d[sel_q]   = 1'b1;
                    cnt_d          = '0;
                    state_d        = ST_RESP;
                end else begin
                    rd_n_d = code_q;
                end
            end
            ST_RESP: begin
                served_d = sel_q ? 2'b10 : 2'b01;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            served_q     <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            code_q       <= TXN_NONE;
            cnt_q        <= '0;
            wr_n_q       <= TXN_NONE;
            rd_n_q       <= TXN_NONE;
            ready_q      <= '0;
            err_q        <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            served_q     <= served_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            code_q       <= code_d;
            cnt_q        <= cnt_d;
            wr_n_q       <= wr_n_d;
            rd_n_q       <= rd_n_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    assign p_address      = addr_q;
    assign p_data_in      = wdata_q;
    assign p_data_write_n = wr_n_q;
    assign p_data_read_n  = rd_n_q;
    assign r0_ready       = ready_q[0];
    assign r1_ready       = ready_q[1];
    assign r0_err         = err_q[0];
    assign r1_err         = err_q[1];
    assign r0_rdata       = rdata0_q;
    assign r1_rdata       = rdata1_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter: vector table of single transactions plus
// hand sequences for the reset tie-break, continuous alternation and reset mid-read.
module tb_periph_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic [1:0]  r0_write_n, r0_read_n, r1_write_n, r1_read_n;
    logic [31:0] r0_rdata, r1_rdata;
    logic        r0_ready, r1_ready, r0_err, r1_err;
    logic [5:0]  p_address;
    logic [31:0] p_data_in;
    logic [1:0]  p_data_write_n, p_data_read_n;
    logic [31:0] p_data_out;
    logic        p_data_ready = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    int          periph_delay = 0;
    logic [31:0] periph_data = 32'h0;
    int          rd_cnt = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .r0_addr        (r0_addr),
        .r0_wdata       (r0_wdata),
        .r0_write_n     (r0_write_n),
        .r0_read_n      (r0_read_n),
        .r0_rdata       (r0_rdata),
        .r0_ready       (r0_ready),
        .r0_err         (r0_err),
        .r1_addr        (r1_addr),
        .r1_wdata       (r1_wdata),
        .r1_write_n     (r1_write_n),
        .r1_read_n      (r1_read_n),
        .r1_rdata       (r1_rdata),
        .r1_ready       (r1_ready),
        .r1_err         (r1_err),
        .p_address      (p_address),
        .p_data_in      (p_data_in),
        .p_data_write_n (p_data_write_n),
        .p_data_read_n  (p_data_read_n),
        .p_data_out     (p_data_out),
        .p_data_ready   (p_data_ready),
        .busy           (busy)
    );

    // Peripheral: acknowledges in the periph_delay-th cycle of a read strobe; 0 = never.
    assign p_data_out = periph_data;
    always @(negedge clk) begin
        if (p_data_read_n != 2'b11) begin
            rd_cnt = rd_cnt + 1;
            p_data_ready = (periph_delay != 0) && (rd_cnt == periph_delay);
        end else begin
            rd_cnt = 0;
            p_data_ready = 1'b0;
        end
    end

    typedef struct {
        logic        req1;
        logic [1:0]  wn;
        logic [1:0]  rn;
        logic [5:0]  addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] pdata;
        int          exp_ready_cyc;
        logic [1:0]  exp_wr_code;
        int          exp_rd_cycles;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mk(input logic req1, input logic [1:0] wn, input logic [1:0] rn,
                                input logic [5:0] addr, input logic [31:0] wdata, input int delay,
                                input logic [31:0] pdata, input int exp_ready_cyc,
                                input logic [1:0] exp_wr_code, input int exp_rd_cycles,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.req1 = req1; v.wn = wn; v.rn = rn; v.addr = addr; v.wdata = wdata;
        v.delay = delay; v.pdata = pdata; v.exp_ready_cyc = exp_ready_cyc;
        v.exp_wr_code = exp_wr_code; v.exp_rd_cycles = exp_rd_cycles;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic r1, input logic [1:0] wn, input logic [1:0] rn,
                           input logic [5:0] addr, input logic [31:0] wdata);
        if (r1) begin
            r1_write_n = wn; r1_read_n = rn; r1_addr = addr; r1_wdata = wdata;
        end else begin
            r0_write_n = wn; r0_read_n = rn; r0_addr = addr; r0_wdata = wdata;
        end
    endtask

    task automatic clr_req(input logic r1);
        set_req(r1, 2'b11, 2'b11, 6'h0, 32'h0);
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int          ready_cyc = -1;
        int          wr_cnt = 0;
        int          wr_cyc = -1;
        int          rd_cyc = 0;
        int          other_rdy = 0;
        logic [1:0]  wr_code = 2'b11;
        logic [5:0]  wr_addr = 6'h0;
        logic [31:0] wr_data = 32'h0;
        logic [31:0] got_rdata = 32'hFFFF_FFFF;
        logic        got_err = 1'bx;
        logic [1:0]  rd_at_ready = 2'b00;
        logic        busy_at_ready = 1'b0;
        periph_delay = v.delay;
        periph_data  = v.pdata;
        @(posedge clk);
        #1 set_req(v.req1, v.wn, v.rn, v.addr, v.wdata);
        for (int c = 0; c < 300 && ready_cyc < 0; c++) begin
            @(negedge clk);
            if (p_data_write_n != 2'b11) begin
                wr_cnt++; wr_cyc = c; wr_code = p_data_write_n;
                wr_addr = p_address; wr_data = p_data_in;
            end
            if (p_data_read_n != 2'b11) rd_cyc++;
            if (v.req1 ? r0_ready : r1_ready) other_rdy++;
            if (v.req1 ? r1_ready : r0_ready) begin
                ready_cyc     = c;
                got_rdata     = v.req1 ? r1_rdata : r0_rdata;
                got_err       = v.req1 ? r1_err : r0_err;
                rd_at_ready   = p_data_read_n;
                busy_at_ready = busy;
            end
        end
        @(posedge clk);
        #1 clr_req(v.req1);
        @(negedge clk);
        chk($sformatf("%s busy_after", tag), {31'h0, busy}, 32'h0);
        chk($sformatf("%s ready_cycle", tag), ready_cyc, v.exp_ready_cyc);
        chk($sformatf("%s rdata", tag), got_rdata, v.exp_rdata);
        chk($sformatf("%s err", tag), {31'h0, got_err}, {31'h0, v.exp_err});
        chk($sformatf("%s rd_strobe_cycles", tag), rd_cyc, v.exp_rd_cycles);
        chk($sformatf("%s rd_strobe_at_ready", tag), {30'h0, rd_at_ready}, 32'h3);
        chk($sformatf("%s busy_at_ready", tag), {31'h0, busy_at_ready}, 32'h1);
        chk($sformatf("%s other_ready", tag), other_rdy, 0);
        chk($sformatf("%s wr_strobes", tag), wr_cnt, (v.exp_wr_code != 2'b11) ? 1 : 0);
        if (v.exp_wr_code != 2'b11) begin
            chk($sformatf("%s wr_cycle", tag), wr_cyc, 1);
            chk($sformatf("%s wr_code", tag), {30'h0, wr_code}, {30'h0, v.exp_wr_code});
            chk($sformatf("%s wr_addr", tag), {26'h0, wr_addr}, {26'h0, v.addr});
            chk($sformatf("%s wr_data", tag), wr_data, v.wdata);
        end
    endtask

    initial begin
        logic [5:0] seen[6];
        int         n_seen;

        vecs[0] = mk(1'b0, 2'b10, 2'b11, 6'h05, 32'hDEADBEEF, 0,   32'h0,        2,   2'b10, 0,   32'h0,        1'b0);
        vecs[1] = mk(1'b1, 2'b11, 2'b00, 6'h10, 32'h0,        3,   32'h12345678, 4,   2'b11, 3,   32'h00000078, 1'b0);
        vecs[2] = mk(1'b1, 2'b11, 2'b01, 6'h10, 32'h0,        3,   32'h12345678, 4,   2'b11, 3,   32'h00005678, 1'b0);
        vecs[3] = mk(1'b0, 2'b11, 2'b10, 6'h3F, 32'h0,        1,   32'hCAFEF00D, 2,   2'b11, 1,   32'hCAFEF00D, 1'b0);
        vecs[4] = mk(1'b1, 2'b00, 2'b11, 6'h01, 32'h000000AA, 0,   32'h0,        2,   2'b00, 0,   32'h0,        1'b0);
        vecs[5] = mk(1'b0, 2'b01, 2'b10, 6'h22, 32'h0000BEEF, 1,   32'h55555555, 2,   2'b01, 0,   32'h0,        1'b0);
        vecs[6] = mk(1'b0, 2'b11, 2'b10, 6'h07, 32'h0,        0,   32'hFFFFFFFF, 256, 2'b11, 255, 32'h0,        1'b1);
        vecs[7] = mk(1'b1, 2'b11, 2'b10, 6'h08, 32'h0,        255, 32'h0BADF00D, 256, 2'b11, 255, 32'h0BADF00D, 1'b0);

        rst_n = 1'b0;
        clr_req(1'b0);
        clr_req(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset write_n", {30'h0, p_data_write_n}, 32'h3);
        chk("reset read_n", {30'h0, p_data_read_n}, 32'h3);
        chk("reset p_address", {26'h0, p_address}, 32'h0);
        chk("reset p_data_in", p_data_in, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset ready", {30'h0, r1_ready, r0_ready}, 32'h0);
        chk("reset err", {30'h0, r1_err, r0_err}, 32'h0);
        chk("reset r0_rdata", r0_rdata, 32'h0);
        chk("reset r1_rdata", r1_rdata, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Same-cycle tie right after reset, then both hold continuously.
        @(posedge clk);
        #1;
        set_req(1'b0, 2'b10, 2'b11, 6'h0A, 32'h11111111);
        set_req(1'b1, 2'b10, 2'b11, 6'h0B, 32'h22222222);
        n_seen = 0;
        for (int c = 0; c < 40 && n_seen < 6; c++) begin
            @(negedge clk);
            if (p_data_write_n != 2'b11) begin
                seen[n_seen] = p_address;
                if (n_seen == 0) chk("tie first data", p_data_in, 32'h11111111);
                n_seen++;
            end
        end
        chk("alternate strobe count", n_seen, 6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("alternate grant %0d", i), {26'h0, seen[i]}, (i % 2 == 0) ? 32'h0A : 32'h0B);
        @(posedge clk);
        #1;
        clr_req(1'b0);
        clr_req(1'b1);
        repeat (4) @(posedge clk);

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset while a read is outstanding.
        periph_delay = 0;
        @(posedge clk);
        #1 set_req(1'b1, 2'b11, 2'b10, 6'h12, 32'h0);
        repeat (5) @(negedge clk);
        chk("midrd read strobe", {30'h0, p_data_read_n}, 32'h2);
        chk("midrd busy", {31'h0, busy}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrd reset read_n", {30'h0, p_data_read_n}, 32'h3);
        chk("midrd reset write_n", {30'h0, p_data_write_n}, 32'h3);
        chk("midrd reset busy", {31'h0, busy}, 32'h0);
        chk("midrd reset ready", {30'h0, r1_ready, r0_ready}, 32'h0);
        clr_req(1'b1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_txn(mk(1'b1, 2'b11, 2'b00, 6'h12, 32'h0, 2, 32'hA5A5A5A5, 3, 2'b11, 2, 32'h000000A5, 1'b0),
               "reissue");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
